// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type ids, default flit geometry and the
// one-hot state encodings of the per-output VC allocator.
package noc_pkg;

    localparam logic [1:0] HEADER_ID = 2'b01;
    localparam logic [1:0] BODY_ID   = 2'b10;
    localparam logic [1:0] TAIL_ID   = 2'b11;

    localparam int NOC_FLIT_DATA_W = 8;
    localparam int NOC_FLIT_ID_W   = 2;
    localparam int NOC_FLIT_W      = NOC_FLIT_DATA_W + NOC_FLIT_ID_W;

    localparam logic [2:0] ALLOC_IDLE = 3'b001;
    localparam logic [2:0] ALLOC_HEAD = 3'b010;
    localparam logic [2:0] ALLOC_BODY = 3'b100;

    // Next index in a ring of n entries.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/vc_output_allocator_rr_arbiter.sv
// Combinational round-robin arbiter: the lowest requesting index at or after
// ptr (cyclically) wins; returns one-hot grant and the winner's index.
module rr_arbiter #(
    parameter int VC_NUM = 4,
    parameter int IDX_W  = $clog2(VC_NUM)
) (
    input  logic [VC_NUM-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [VC_NUM-1:0] gnt,
    output logic [IDX_W-1:0]  gnt_idx
);

    always_comb begin
        int k;
        k       = 0;
        gnt     = '0;
        gnt_idx = '0;
        // Walk from the farthest offset back to ptr so the nearest requester overwrites.
        for (int i = VC_NUM - 1; i >= 0; i--) begin
            k = int'(ptr) + i;
            if (k >= VC_NUM) begin
                k = k - VC_NUM;
            end
            if (req[k]) begin
                gnt     = '0;
                gnt[k]  = 1'b1;
                gnt_idx = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/vc_output_allocator.sv
// Output-port VC allocator and crossbar leg: round-robin grant per packet,
// forwards header then body/tail flits of the granted VC with one-cycle latency.
// Optional packet counter output enabled by VC_OUT_ALLOC_PKT_CNT_EN.
module vc_output_allocator
    import noc_pkg::*;
#(
    parameter int VC_NUM      = 4,
    parameter int FLIT_DATA_W = NOC_FLIT_DATA_W,
    parameter int FLIT_ID_W   = NOC_FLIT_ID_W,
    parameter int DEST_W      = 2,
    parameter int PORT_ID     = 0
) (
    input  logic                                      clk_i,
    input  logic                                      rst_ni,
    input  logic [VC_NUM*(FLIT_DATA_W+FLIT_ID_W)-1:0] header_i,
    input  logic [VC_NUM*(FLIT_DATA_W+FLIT_ID_W)-1:0] data_i,
    input  logic [VC_NUM-1:0]                         data_vld_i,
    input  logic                                      chan_rdy_i,
    output logic [VC_NUM-1:0]                         chan_alloc_o,
    output logic [FLIT_DATA_W+FLIT_ID_W-1:0]          data_o,
`ifdef VC_OUT_ALLOC_PKT_CNT_EN
    output logic [15:0]                               pkt_cnt_o,
`endif
    output logic                                      wr_en_o
);

    localparam int FLIT_W = FLIT_DATA_W + FLIT_ID_W;
    localparam int IDX_W  = $clog2(VC_NUM);

    logic [FLIT_W-1:0] hdr_vc [VC_NUM];
    logic [FLIT_W-1:0] dat_vc [VC_NUM];
    logic [VC_NUM-1:0] req;
    logic [VC_NUM-1:0] arb_gnt;
    logic [IDX_W-1:0]  arb_idx;
    logic              arb_vld;

    logic [2:0]        state;
    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  g;
    logic              tail_acc;
    logic [FLIT_W-1:0] data_p1;
    logic              vld_p1;

    for (genvar k = 0; k < VC_NUM; k++) begin : g_req
        assign hdr_vc[k] = header_i[k*FLIT_W +: FLIT_W];
        assign dat_vc[k] = data_i[k*FLIT_W +: FLIT_W];
        assign req[k]    = (hdr_vc[k][FLIT_W-1 -: FLIT_ID_W] == FLIT_ID_W'(HEADER_ID)) &&
                           (hdr_vc[k][DEST_W-1:0] == DEST_W'(PORT_ID));
    end

    rr_arbiter #(
        .VC_NUM (VC_NUM),
        .IDX_W  (IDX_W)
    ) u_rr_arbiter (
        .req     (req),
        .ptr     (ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    assign arb_vld  = |arb_gnt;
    assign tail_acc = (state == ALLOC_BODY) && data_vld_i[g] &&
                      (dat_vc[g][FLIT_W-1 -: FLIT_ID_W] == FLIT_ID_W'(TAIL_ID));

    // Stage p1: granted VC's flit registered towards the downstream FIFO.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state   <= ALLOC_IDLE;
            ptr     <= '0;
            g       <= '0;
            data_p1 <= '0;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= 1'b0;
            case (state)
                ALLOC_IDLE: begin
                    if (arb_vld) begin
                        g     <= arb_idx;
                        state <= ALLOC_HEAD;
                    end
                end
                ALLOC_HEAD: begin
                    if (chan_rdy_i) begin
                        data_p1 <= hdr_vc[g];
                        vld_p1  <= 1'b1;
                        state   <= ALLOC_BODY;
                    end
                end
                ALLOC_BODY: begin
                    // No backpressure here: the upstream VC already gates its reads.
                    if (data_vld_i[g]) begin
                        data_p1 <= dat_vc[g];
                        vld_p1  <= 1'b1;
                    end
                    if (tail_acc) begin
                        state <= ALLOC_IDLE;
                        ptr   <= IDX_W'(wrap_inc(int'(g), VC_NUM));
                    end
                end
                default: state <= ALLOC_IDLE;
            endcase
        end
    end

    always_comb begin
        chan_alloc_o = '0;
        if (state != ALLOC_IDLE) begin
            chan_alloc_o[g] = 1'b1;
        end
    end

    assign data_o  = data_p1;
    assign wr_en_o = vld_p1;

`ifdef VC_OUT_ALLOC_PKT_CNT_EN
    logic [15:0] pkt_cnt_p1;

    // Counts alongside the tail's write pulse; wraps naturally at 16 bits.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pkt_cnt_p1 <= '0;
        end else if (tail_acc) begin
            pkt_cnt_p1 <= pkt_cnt_p1 + 16'd1;
        end
    end

    assign pkt_cnt_o = pkt_cnt_p1;
`endif

endmodule

// File: tb/tb_vc_output_allocator.sv
// Bench for vc_output_allocator: directed packets plus randomized traffic
// against a packet-level reference model.
`timescale 1ns/1ps
module tb_vc_output_allocator;

    localparam int VC   = 4;
    localparam int FW   = 10;
    localparam int PORT = 0;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [VC*FW-1:0]  header;
    logic [VC*FW-1:0]  data;
    logic [VC-1:0]     vld;
    logic              rdy;
    logic [VC-1:0]     alloc;
    logic [FW-1:0]     dout;
    logic              wr;
`ifdef VC_OUT_ALLOC_PKT_CNT_EN
    logic [15:0]       pkt_cnt;
`endif

    always #5 clk = ~clk;

    vc_output_allocator #(
        .VC_NUM      (VC),
        .FLIT_DATA_W (8),
        .FLIT_ID_W   (2),
        .DEST_W      (2),
        .PORT_ID     (PORT)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .header_i     (header),
        .data_i       (data),
        .data_vld_i   (vld),
        .chan_rdy_i   (rdy),
        .chan_alloc_o (alloc),
        .data_o       (dout),
`ifdef VC_OUT_ALLOC_PKT_CNT_EN
        .pkt_cnt_o    (pkt_cnt),
`endif
        .wr_en_o      (wr)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: which VC owns the port, whether its header has gone out,
    // the round-robin start point, and the last flit written downstream.
    bit          m_busy;
    bit          m_head_done;
    int          m_owner;
    int          m_ptr;
    logic [3:0]  m_alloc;
    logic [9:0]  m_data;
    logic        m_wr;
    logic [15:0] m_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [9:0] flit_of(input logic [VC*FW-1:0] bus, input int k);
        return bus[k*FW +: FW];
    endfunction

    task automatic set_hdr(input int k, input logic [9:0] f);
        header[k*FW +: FW] = f;
    endtask

    task automatic set_dat(input int k, input logic [9:0] f);
        data[k*FW +: FW] = f;
    endtask

    task automatic model_step();
        logic [9:0] f;
        int k;
        if (!rst_n) begin
            m_busy = 0; m_head_done = 0; m_owner = 0; m_ptr = 0;
            m_data = '0; m_wr = 1'b0; m_cnt = '0;
        end else begin
            m_wr = 1'b0;
            if (!m_busy) begin
                for (int i = 0; i < VC; i++) begin
                    k = (m_ptr + i) % VC;
                    f = flit_of(header, k);
                    if (!m_busy && f[9:8] == 2'b01 && int'(f[1:0]) == PORT) begin
                        m_busy = 1; m_owner = k; m_head_done = 0;
                    end
                end
            end else if (!m_head_done) begin
                if (rdy) begin
                    m_data = flit_of(header, m_owner); m_wr = 1'b1; m_head_done = 1;
                end
            end else if (vld[m_owner]) begin
                f = flit_of(data, m_owner);
                m_data = f; m_wr = 1'b1;
                if (f[9:8] == 2'b11) begin
                    m_busy = 0; m_ptr = (m_owner + 1) % VC; m_cnt = m_cnt + 16'd1;
                end
            end
        end
        m_alloc = m_busy ? 4'(1 << m_owner) : 4'b0000;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("alloc", 32'(alloc), 32'(m_alloc));
        check("wr_en", 32'(wr), 32'(m_wr));
        check("data",  32'(dout), 32'(m_data));
`ifdef VC_OUT_ALLOC_PKT_CNT_EN
        check("pkt_cnt", 32'(pkt_cnt), 32'(m_cnt));
`endif
    endtask

    task automatic rand_flit_inputs();
        logic [9:0] f;
        int r;
        for (int k = 0; k < VC; k++) begin
            r = $urandom_range(0, 9);
            f = 10'($urandom);
            if (r < 4) f = '0;
            else begin
                if (r < 9) f[9:8] = 2'b01;
                if ($urandom_range(0, 2) != 0) f[1:0] = 2'(PORT);
            end
            set_hdr(k, f);
            f = 10'($urandom);
            f[9:8] = 2'($urandom_range(1, 3));
            set_dat(k, f);
        end
        vld = 4'($urandom);
        rdy = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        rst_n = 1'b0; header = '0; data = '0; vld = '0; rdy = 1'b0;
        tick(); tick();
        check("rst_alloc", 32'(alloc), 32'h0);
        check("rst_wr", 32'(wr), 32'h0);
        check("rst_data", 32'(dout), 32'h0);
        rst_n = 1'b1;

        // Single packet on VC1
        set_hdr(1, 10'h100);
        tick();
        check("p1_grant", 32'(alloc), 32'h2);
        rdy = 1'b1;
        tick();
        check("p1_head", 32'(dout), 32'h100);
        check("p1_head_wr", 32'(wr), 32'h1);
        set_hdr(1, 10'h000);
        vld = 4'b0010; set_dat(1, 10'h211);
        tick();
        check("p1_body", 32'(dout), 32'h211);
        set_dat(1, 10'h322);
        tick();
        check("p1_tail", 32'(dout), 32'h322);
        check("p1_release", 32'(alloc), 32'h0);
        vld = '0;
        tick();
        check("p1_idle_wr", 32'(wr), 32'h0);

        // Pointer now 2: VC2 must beat VC0
        set_hdr(0, 10'h100); set_hdr(2, 10'h100);
        tick();
        check("ptr2_grant", 32'(alloc), 32'h4);
        tick();
        set_hdr(2, 10'h000);
        vld = 4'b0100; set_dat(2, 10'h3AA);
        tick();
        vld = '0;
        tick();
        check("vc0_grant", 32'(alloc), 32'h1);
        tick();
        set_hdr(0, 10'h000);
        vld = 4'b0100; set_dat(2, 10'h2EE); set_dat(0, 10'h2CC);
        tick();
        check("ignore_vc2", 32'(wr), 32'h0);
        vld = 4'b0001; set_dat(0, 10'h3CC);
        tick();
        check("vc0_tail", 32'(dout), 32'h3CC);
        vld = '0;

        // Destination mismatch never requests
        set_hdr(0, 10'h101);
        repeat (3) begin
            tick();
            check("dest_mis_alloc", 32'(alloc), 32'h0);
        end
        set_hdr(0, 10'h000);

        // chan_rdy held low in HEAD, then reset mid-body
        set_hdr(3, 10'h100); rdy = 1'b0;
        tick();
        repeat (5) begin
            tick();
            check("hold_alloc", 32'(alloc), 32'h8);
            check("hold_wr", 32'(wr), 32'h0);
        end
        rdy = 1'b1;
        tick();
        check("late_head", 32'(dout), 32'h100);
        set_hdr(3, 10'h000);
        vld = 4'b1000; set_dat(3, 10'h255);
        tick();
        rst_n = 1'b0; vld = '0;
        tick();
        check("midrst_alloc", 32'(alloc), 32'h0);
        check("midrst_data", 32'(dout), 32'h0);
        rst_n = 1'b1;

        // Randomized traffic, occasional resets
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            rand_flit_inputs();
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
